cdr_frame_ctrl: RTL and testbench
=================================

Name: cdr_frame_ctrl

Overview:
- Sequencer that sits directly behind the oversampling CDR and consumes its recovered bit stream (data bit plus one-cycle enable per bit).
- Hunts for a fixed sync byte, verifies frame alignment over several frames, declares lock, and emits payload bytes.
- Tracks sync loss and flywheels through isolated bad syncs.
- Issues a timed reset pulse to the CDR when hunting fails for too long, restarting its phase acquisition.

Parameters:
- SYNC_WORD, 8'hA5, frame sync byte (MSB first).
- PAYLOAD_BYTES, 4, payload bytes per frame after sync; range 1..255.
- VERIFY_CNT, 3, consecutive good syncs needed to lock; range 1..15.
- LOSS_CNT, 2, consecutive bad syncs that drop lock; range 1..15.
- RESYNC_TIMEOUT, 200000, CLOCK_10 cycles in HUNT before a CDR reset is issued.
- CDR_RST_LEN, 16, cycles that cdr_reset is held high.

Ports:
- CLOCK_10  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- bit_in  in  1  recovered data bit from CDR.
- bit_en  in  1  one-cycle strobe; bit_in valid when high.
- cdr_reset  out  1  reset request to CDR, held CDR_RST_LEN cycles.
- byte_out  out  8  payload byte; MSB is first received bit.
- byte_valid  out  1  one-cycle strobe qualifying byte_out.
- frame_start  out  1  high with byte_valid for the first payload byte of each frame.
- locked  out  1  high in LOCKED state.
- sync_err_cnt  out  16  saturating count of sync mismatches seen in VERIFY/LOCKED.

Behaviour:
- Reset (async, active-high): state=HUNT; every output, shifter and counter = 0. Reset mid-frame discards the partial byte and frame.
- Shifter: sr <= {sr[6:0], bit_in} on each bit_en. All outputs are registered.
- Bit/byte counters: bit_cnt 0..7, byte_cnt 0..PAYLOAD_BYTES. byte_cnt==0 means the sync slot. Both advance only on bit_en.
- States are HUNT, VERIFY, LOCKED, CDR_RST.
- HUNT:
  - fill counter saturates at 8 bits; a match is checked only once fill ≥8.
  - On the bit_en whose updated sr == SYNC_WORD: go to VERIFY with good=1, byte_cnt=1, bit_cnt=0.
  - Watchdog counts every CLOCK_10 cycle in HUNT and clears on HUNT entry. At RESYNC_TIMEOUT-1 → CDR_RST.
- VERIFY:
  - Frame-counts bits and emits no bytes.
  - At each completed sync slot, compare sr to SYNC_WORD.
  - Match: good++; when good reaches VERIFY_CNT → LOCKED. With VERIFY_CNT=1, lock occurs on the HUNT match itself.
  - Mismatch: sync_err_cnt++ and → HUNT with fill=0.
- LOCKED:
  - locked=1.
  - At each completed payload byte, byte_valid pulses and byte_out=sr one cycle after the 8th bit_en.
  - frame_start accompanies byte_cnt==1.
  - Sync slot match: miss=0. Sync slot mismatch: miss++, sync_err_cnt++. When miss reaches LOSS_CNT → HUNT and locked falls the same cycle as the transition.
  - A frame with bad sync and miss<LOSS_CNT still emits its payload (flywheel).
- CDR_RST:
  - cdr_reset=1 for exactly CDR_RST_LEN cycles; bit_en is ignored.
  - Shifter and fill are cleared, then → HUNT with the watchdog cleared.
- Simultaneous events: a bit_en on the cycle of any state transition is consumed by the new state's counters only if the transition was not caused by that bit.
- sync_err_cnt saturates at 16'hFFFF and is cleared only by reset.
- Counter widths come from $clog2 of the parameters; no wrap other than the declared ranges.

Decomposition:
- Shared package `cdr_pkg`: state enum (HUNT, VERIFY, LOCKED, CDR_RST), default SYNC_WORD, and the CDR bit period constant (1000 cycles).
- Sub-module `cdr_bit_deser`: shifter, bit_cnt and byte-complete strobe. The FSM, frame counting, watchdog and statistics stay in the top.

Test Plan:
- Bits driven at one bit_en every 1000 cycles, 3 frames of A5+{11,22,33,44} → locked rises after the 3rd sync. The 4th frame yields byte_valid ×4 with 11,22,33,44 and frame_start on 11.
- While locked, one frame with sync 5A → sync_err_cnt=1, locked stays 1, payload still emitted. The next good sync clears miss.
- While locked, two consecutive bad syncs → locked=0 after the 2nd, state HUNT, sync_err_cnt=2, no further byte_valid.
- Constant-0 input with RESYNC_TIMEOUT=5000 overridden → cdr_reset high for 16 cycles starting cycle 5000 after HUNT entry, repeating every 5016 cycles.
- Payload byte equal to A5 placed off-alignment during HUNT → false VERIFY entry, mismatch at the next sync slot returns to HUNT, then true lock is acquired.
- reset asserted mid-payload while locked → all outputs 0 immediately (async). After release, full re-acquisition is required (3 syncs).

Source files
------------

// File: rtl/cdr_pkg.sv
// Shared definitions for the CDR frame controller.
//   cdr_state_e    : frame sequencer states
//   SYNC_WORD_DFLT : default frame sync byte, transmitted MSB first
//   BIT_PERIOD     : nominal CLOCK_10 cycles per recovered bit from the CDR
package cdr_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    VERIFY  = 2'd1,
    LOCKED  = 2'd2,
    CDR_RST = 2'd3
  } cdr_state_e;

  localparam logic [7:0]  SYNC_WORD_DFLT = 8'hA5;
  localparam int unsigned BIT_PERIOD     = 1000;

endpackage

// File: rtl/cdr_frame_ctrl_deser.sv
// Bit deserialiser behind the CDR.
//   clk, rst    : clock, async active-high reset
//   bit_in      : recovered bit
//   bit_en      : shift strobe (already gated by the sequencer)
//   clr         : zero the shifter and bit counter this cycle; a strobe on the
//                 same cycle shifts into the cleared register
//   align       : force bit_cnt to 0 after this strobe (sync found in HUNT)
//   sr_next     : shifter contents including the current bit
//   byte_done   : strobe completes the 8th bit of a byte
module cdr_bit_deser (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_en,
  input  logic       clr,
  input  logic       align,
  output logic [7:0] sr_next,
  output logic       byte_done
);

  logic [7:0] sr_q, sr_d, sr_base;
  logic [2:0] bit_cnt_q, bit_cnt_d, cnt_base;

  // Separate continuous assigns keep sr_next/byte_done independent of align,
  // so the sequencer can derive align from sr_next without a comb loop.
  assign sr_base   = clr ? 8'd0 : sr_q;
  assign cnt_base  = clr ? 3'd0 : bit_cnt_q;
  assign sr_next   = {sr_base[6:0], bit_in};
  assign byte_done = bit_en && (cnt_base == 3'd7);

  always_comb begin
    sr_d      = sr_base;
    bit_cnt_d = cnt_base;
    if (bit_en) begin
      sr_d      = sr_next;
      bit_cnt_d = align ? 3'd0 : cnt_base + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/cdr_frame_ctrl.sv
// Frame sequencer behind the oversampling CDR: hunts for the sync byte,
// verifies alignment over VERIFY_CNT frames, emits payload bytes while locked,
// flywheels through isolated bad syncs and pulses cdr_reset if HUNT times out.
//   CLOCK_10, reset : clock, async active-high reset
//   bit_in, bit_en  : recovered bit and its one-cycle strobe
//   cdr_reset       : CDR restart request, high CDR_RST_LEN cycles
//   byte_out        : payload byte (MSB = first bit), qualified by byte_valid
//   frame_start     : with byte_valid on the first payload byte of a frame
//   locked          : sequencer is in LOCKED
//   sync_err_cnt    : saturating count of bad syncs in VERIFY/LOCKED
module cdr_frame_ctrl
  import cdr_pkg::*;
#(
  parameter logic [7:0]  SYNC_WORD      = SYNC_WORD_DFLT,
  parameter int unsigned PAYLOAD_BYTES  = 4,
  parameter int unsigned VERIFY_CNT     = 3,
  parameter int unsigned LOSS_CNT       = 2,
  parameter int unsigned RESYNC_TIMEOUT = 200000,
  parameter int unsigned CDR_RST_LEN    = 16
) (
  input  logic        CLOCK_10,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_en,
  output logic        cdr_reset,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [15:0] sync_err_cnt
);

  localparam int BCW = $clog2(PAYLOAD_BYTES + 1);
  localparam int GW  = $clog2(VERIFY_CNT + 1);
  localparam int MW  = $clog2(LOSS_CNT + 1);
  localparam int WDW = $clog2(RESYNC_TIMEOUT + 1);
  localparam int RW  = $clog2(CDR_RST_LEN + 1);

  localparam logic [BCW-1:0] PB_LAST   = BCW'(PAYLOAD_BYTES);
  localparam logic [BCW-1:0] BC_ONE    = BCW'(1);
  localparam logic [GW-1:0]  GOOD_LOCK = GW'(VERIFY_CNT);
  localparam logic [GW-1:0]  G_ONE     = GW'(1);
  localparam logic [MW-1:0]  MISS_DROP = MW'(LOSS_CNT);
  localparam logic [MW-1:0]  M_ONE     = MW'(1);
  localparam logic [WDW-1:0] WD_LAST   = WDW'(RESYNC_TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_ONE    = WDW'(1);
  localparam logic [RW-1:0]  RST_LAST  = RW'(CDR_RST_LEN - 1);
  localparam logic [RW-1:0]  R_ONE     = RW'(1);

  cdr_state_e     state_q, state_d;
  logic [3:0]     fill_q, fill_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]  good_q, good_d;
  logic [MW-1:0]  miss_q, miss_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [RW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [15:0]    err_q, err_d;
  logic [7:0]     byte_out_q, byte_out_d;
  logic           byte_valid_q, byte_valid_d;
  logic           frame_start_q, frame_start_d;
  logic           locked_q, locked_d;
  logic           cdr_reset_q, cdr_reset_d;

  logic [7:0] sr_next;
  logic       byte_done, sync_ok, align, err_inc;
  logic       wd_fire, rst_last, des_en, des_clr;

  assign wd_fire  = (state_q == HUNT) && (wd_q == WD_LAST);
  assign rst_last = (state_q == CDR_RST) && (rst_cnt_q == RST_LAST);
  // CDR_RST ignores bits except on its last cycle, where the new HUNT state
  // takes the bit into a freshly cleared shifter. A timeout drops the bit.
  assign des_en   = bit_en && ((state_q == CDR_RST) ? rst_last : !wd_fire);
  assign des_clr  = (state_q == CDR_RST);
  assign sync_ok  = (sr_next == SYNC_WORD);

  cdr_bit_deser u_deser (
    .clk       (CLOCK_10),
    .rst       (reset),
    .bit_in    (bit_in),
    .bit_en    (des_en),
    .clr       (des_clr),
    .align     (align),
    .sr_next   (sr_next),
    .byte_done (byte_done)
  );

  always_comb begin
    state_d       = state_q;
    fill_d        = fill_q;
    byte_cnt_d    = byte_cnt_q;
    good_d        = good_q;
    miss_d        = miss_q;
    rst_cnt_d     = '0;
    err_inc       = 1'b0;
    align         = 1'b0;
    byte_out_d    = byte_out_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (wd_fire) begin
          state_d = CDR_RST;
        end else if (bit_en) begin
          if ((fill_q >= 4'd7) && sync_ok) begin
            // This bit completes the sync byte: payload byte 1 starts next.
            align      = 1'b1;
            byte_cnt_d = BC_ONE;
            good_d     = G_ONE;
            miss_d     = '0;
            fill_d     = '0;
            state_d    = (VERIFY_CNT == 1) ? LOCKED : VERIFY;
          end else if (fill_q != 4'd8) begin
            fill_d = fill_q + 4'd1;
          end
        end
      end

      VERIFY, LOCKED: begin
        if (byte_done) begin
          if (byte_cnt_q == '0) begin
            byte_cnt_d = BC_ONE;
            if (sync_ok) begin
              miss_d = '0;
              if (state_q == VERIFY) begin
                good_d = good_q + G_ONE;
                if (good_q + G_ONE == GOOD_LOCK) state_d = LOCKED;
              end
            end else begin
              err_inc = 1'b1;
              if (state_q == VERIFY) begin
                state_d = HUNT;
                fill_d  = '0;
              end else begin
                miss_d = miss_q + M_ONE;
                if (miss_q + M_ONE == MISS_DROP) begin
                  state_d = HUNT;
                  fill_d  = '0;
                end
              end
            end
          end else begin
            byte_cnt_d = (byte_cnt_q == PB_LAST) ? '0 : byte_cnt_q + BC_ONE;
            if (state_q == LOCKED) begin
              byte_valid_d  = 1'b1;
              frame_start_d = (byte_cnt_q == BC_ONE);
              byte_out_d    = sr_next;
            end
          end
        end
      end

      CDR_RST: begin
        fill_d = '0;
        if (rst_last) begin
          state_d = HUNT;
          fill_d  = bit_en ? 4'd1 : 4'd0;
        end else begin
          rst_cnt_d = rst_cnt_q + R_ONE;
        end
      end

      default: state_d = HUNT;
    endcase

    // Watchdog runs only while staying in HUNT, so every entry starts at 0.
    wd_d        = ((state_q == HUNT) && (state_d == HUNT)) ? wd_q + WD_ONE : '0;
    err_d       = (err_inc && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
    locked_d    = (state_d == LOCKED);
    cdr_reset_d = (state_d == CDR_RST);
  end

  always_ff @(posedge CLOCK_10 or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      fill_q        <= '0;
      byte_cnt_q    <= '0;
      good_q        <= '0;
      miss_q        <= '0;
      wd_q          <= '0;
      rst_cnt_q     <= '0;
      err_q         <= '0;
      byte_out_q    <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      cdr_reset_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      byte_cnt_q    <= byte_cnt_d;
      good_q        <= good_d;
      miss_q        <= miss_d;
      wd_q          <= wd_d;
      rst_cnt_q     <= rst_cnt_d;
      err_q         <= err_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      cdr_reset_q   <= cdr_reset_d;
    end
  end

  assign cdr_reset    = cdr_reset_q;
  assign byte_out     = byte_out_q;
  assign byte_valid   = byte_valid_q;
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign sync_err_cnt = err_q;

endmodule

// File: tb/tb_cdr_frame_ctrl.sv
// Directed bench for cdr_frame_ctrl. Bits are strobed every GAP cycles (a
// scaled-down CDR bit period) to keep the run short; the watchdog is
// shortened to 5000 cycles.
module tb_cdr_frame_ctrl;
  import cdr_pkg::*;

  localparam int GAP = BIT_PERIOD / 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_en;
  logic        cdr_reset;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        frame_start;
  logic        locked;
  logic [15:0] sync_err_cnt;

  always #5 clk = ~clk;

  cdr_frame_ctrl #(.RESYNC_TIMEOUT(5000)) dut (
    .CLOCK_10     (clk),
    .reset        (rst),
    .bit_in       (bit_in),
    .bit_en       (bit_en),
    .cdr_reset    (cdr_reset),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .frame_start  (frame_start),
    .locked       (locked),
    .sync_err_cnt (sync_err_cnt)
  );

  int n_asrt = 0;
  int n_fail = 0;

  logic [7:0] pay [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  // Capture emitted bytes; byte_valid must follow a captured bit strobe
  // by exactly one cycle, and frame_start must never appear alone.
  logic [7:0] got_b [$];
  logic       got_fs [$];
  logic       en_at_edge = 1'b0;
  int         lat_bad = 0;

  always @(posedge clk) en_at_edge <= bit_en;

  always @(negedge clk) begin
    if (byte_valid) begin
      got_b.push_back(byte_out);
      got_fs.push_back(frame_start);
      if (!en_at_edge) lat_bad <= lat_bad + 1;
    end else if (frame_start) begin
      lat_bad <= lat_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_in = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    repeat (GAP - 2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_payload();
    for (int i = 0; i < 4; i++) send_byte(pay[i]);
  endtask

  task automatic send_frame(input logic [7:0] s);
    send_byte(s);
    send_payload();
  endtask

  task automatic chk_payload(input string tag);
    chk($sformatf("%s nbytes", tag), got_b.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_b.size()) begin
        chk($sformatf("%s byte%0d", tag, i), got_b[i], pay[i]);
        chk($sformatf("%s fs%0d", tag, i), got_fs[i], (i == 0));
      end
    end
    got_b.delete();
    got_fs.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " cdr_reset"},   cdr_reset,    0);
    chk({tag, " byte_out"},    byte_out,     0);
    chk({tag, " byte_valid"},  byte_valid,   0);
    chk({tag, " frame_start"}, frame_start,  0);
    chk({tag, " locked"},      locked,       0);
    chk({tag, " err"},         sync_err_cnt, 0);
  endtask

  int  r1, f1, r2, f2;
  logic prev;

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Acquisition: lock on the 3rd sync, payload from then on.
    send_frame(SYNC_WORD_DFLT);
    send_frame(SYNC_WORD_DFLT);
    chk("verify locked", locked, 0);
    chk("verify no bytes", got_b.size(), 0);
    send_byte(SYNC_WORD_DFLT);
    chk("lock 3rd sync", locked, 1);
    send_payload();
    chk_payload("f3");
    send_frame(SYNC_WORD_DFLT);
    chk_payload("f4");
    chk("f4 err", sync_err_cnt, 0);

    // Single bad sync flywheels, next good sync clears miss.
    send_byte(8'h5A);
    chk("fly err", sync_err_cnt, 1);
    chk("fly locked", locked, 1);
    send_payload();
    chk_payload("fly");
    send_frame(SYNC_WORD_DFLT);
    chk_payload("recover");

    // Two consecutive bad syncs drop lock (first one proves miss was cleared).
    send_byte(8'h5A);
    chk("miss1 locked", locked, 1);
    chk("miss1 err", sync_err_cnt, 2);
    send_payload();
    chk_payload("miss1");
    send_byte(8'h5A);
    chk("miss2 locked", locked, 0);
    chk("miss2 err", sync_err_cnt, 3);
    send_payload();
    chk("miss2 no bytes", got_b.size(), 0);

    // Off-alignment A5 gives a false VERIFY, rejected at the next sync slot.
    send_byte(8'h00);
    send_byte(8'hA5);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'hA5);
    chk("false verify err", sync_err_cnt, 3);
    send_byte(8'h11);
    chk("false reject err", sync_err_cnt, 4);
    chk("false locked", locked, 0);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_frame(SYNC_WORD_DFLT);
    send_frame(SYNC_WORD_DFLT);
    chk("relock pre", locked, 0);
    chk("relock no bytes", got_b.size(), 0);
    send_byte(SYNC_WORD_DFLT);
    chk("relock", locked, 1);
    send_payload();
    chk_payload("relock");
    chk("relock err", sync_err_cnt, 4);

    // Async reset mid-payload, then full re-acquisition.
    send_byte(SYNC_WORD_DFLT);
    send_byte(8'h11);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("pre-rst byte_out", byte_out, 8'h11);
    chk("pre-rst locked", locked, 1);
    got_b.delete(); got_fs.delete();
    #2 rst = 1'b1;
    #1 chk_all_zero("async rst");
    @(negedge clk);
    rst = 1'b0;
    send_frame(SYNC_WORD_DFLT);
    send_frame(SYNC_WORD_DFLT);
    chk("reacq pre", locked, 0);
    send_byte(SYNC_WORD_DFLT);
    chk("reacq", locked, 1);
    send_payload();
    chk_payload("reacq");

    // Watchdog: constant-zero bits from a fresh HUNT entry.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r1 = -1; f1 = -1; r2 = -1; f2 = -1; prev = 1'b0;
    fork
      begin
        for (int n = 0; n < 10040 / GAP; n++) send_bit(1'b0);
      end
      begin
        for (int k = 1; k <= 10040; k++) begin
          @(negedge clk);
          if (cdr_reset && !prev) begin
            if (r1 < 0) r1 = k; else if (r2 < 0) r2 = k;
          end
          if (!cdr_reset && prev) begin
            if (f1 < 0) f1 = k; else if (f2 < 0) f2 = k;
          end
          prev = cdr_reset;
        end
      end
    join
    chk("wd rise1", r1, 5000);
    chk("wd fall1", f1, 5016);
    chk("wd rise2", r2, 10016);
    chk("wd fall2", f2, 10032);
    chk("wd locked", locked, 0);
    chk("wd no bytes", got_b.size(), 0);

    chk("byte_valid timing", lat_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
